rst_seq: RTL and testbench
==========================

// Module: rst_seq
// PURPOSE
//   Reset release sequencer driven by the synchronised core reset. Stretches reset for a fixed
//   cycle count, then releases the memory/peripheral reset and waits for memory init done.
//   After a guard gap it releases the core reset and raises rst_done.
//   Also re-runs the sequence on a software reset request.
// PARAMETERS
//   STRETCH_CYC  16   cycles both resets stay asserted after rst deasserts (>=1)
//   GAP_CYC      4    cycles between mem_init_done accepted and core release (0 allowed)
//   TIMEOUT_CYC  255  max cycles waiting for mem_init_done (only with RST_SEQ_TIMEOUT_EN, >=1)
//   CNT_W        8    counter width; must hold max(STRETCH_CYC,GAP_CYC,TIMEOUT_CYC)-1
// PORTS
//   clk            in   1  single clock; all logic on posedge
//   rst            in   1  synchronous reset, active-high
//   mem_init_done  in   1  level, memory/peripheral init complete; sampled only in S_MEM
//   sw_rst_req     in   1  one-cycle pulse, software reset request
//   o_mem_rst      out  1  memory/peripheral reset, active-high, registered
//   o_core_rst     out  1  core reset, active-high, registered
//   o_rst_done     out  1  high only in S_RUN, registered
//   o_timeout      out  1  sticky: mem init wait timed out, registered
//   o_state        out  3  current FSM state encoding (debug)
// BEHAVIOUR
//   - rst=1 (any state, any cycle): state=S_HOLD, cnt=0, o_mem_rst=1, o_core_rst=1,
//     o_rst_done=0, o_timeout=0. rst dominates sw_rst_req and mem_init_done.
//   - Encodings: S_HOLD=0, S_STRETCH=1, S_MEM=2, S_GAP=3, S_RUN=4. Others illegal -> S_HOLD.
//   - All outputs are registered from next-state. They change on the same edge as the state.
//   - S_HOLD: first edge with rst=0 -> S_STRETCH, cnt=0.
//   - S_STRETCH: cnt++ each edge. At the edge where cnt==STRETCH_CYC-1 -> S_MEM and o_mem_rst=0.
//     rst sampled low at edge E0 => o_mem_rst low after edge E0+STRETCH_CYC.
//   - S_MEM: o_mem_rst=0, o_core_rst=1.
//     mem_init_done=1 at edge E -> S_GAP with cnt=0, or S_RUN directly if GAP_CYC==0.
//   - S_GAP: cnt++. At the edge where cnt==GAP_CYC-1 -> S_RUN.
//     o_core_rst=0 and o_rst_done=1 take effect on that edge.
//     mem_init_done accepted at edge E => o_core_rst low after edge E+GAP_CYC.
//   - S_RUN: holds until sw_rst_req.
//     mem_init_done is ignored in S_GAP and S_RUN; it may drop without effect.
//   - sw_rst_req=1 in S_RUN: on that edge -> S_STRETCH, cnt=0.
//     o_mem_rst=1, o_core_rst=1 and o_rst_done=0 are set on the same edge.
//   - sw_rst_req=1 in S_STRETCH: cnt restarts at 0, which extends the stretch.
//     In S_MEM/S_GAP: -> S_STRETCH, cnt=0, o_mem_rst=1 on that edge. In S_HOLD: ignored.
//   - Counter compares are equality against parameter-1, truncated to CNT_W.
//     The counter never wraps within a state and is cleared on every state change.
//   - o_timeout is unaffected by sw_rst_req; only rst clears it.
// CONFIGURATION
//   RST_SEQ_TIMEOUT_EN defined:
//     - S_MEM also counts cnt++ each edge.
//     - At the edge where cnt==TIMEOUT_CYC-1 with mem_init_done=0: -> S_GAP (or S_RUN if
//       GAP_CYC==0) and o_timeout=1, sticky. The sequence then continues normally.
//     - If done and timeout coincide on the same edge, done wins and o_timeout stays 0.
//   Not defined: S_MEM waits indefinitely, no timeout counter logic, o_timeout tied to 0.
// TESTING  (STRETCH_CYC=16, GAP_CYC=4, TIMEOUT_CYC=32, CNT_W=8)
//   1. rst=1 for 5 cycles, then 0; mem_init_done=1 from the start
//      -> o_mem_rst low exactly 16 edges after rst is first sampled 0.
//      -> o_core_rst low and o_rst_done=1 exactly 4 edges later.
//   2. mem_init_done rises 10 cycles after o_mem_rst falls
//      -> o_core_rst stays 1 until 4 edges after done is sampled.
//      -> Dropping done in S_GAP has no effect.
//   3. sw_rst_req pulse in S_RUN
//      -> next edge: o_mem_rst=1, o_core_rst=1, o_rst_done=0.
//      -> The full 16+wait+4 sequence replays.
//   4. rst=1 asserted mid-S_GAP (and mid-S_STRETCH)
//      -> next edge: all outputs at reset values, state=S_HOLD; restart is a clean sequence.
//   5. RST_SEQ_TIMEOUT_EN with mem_init_done held 0
//      -> 32 edges in S_MEM, then o_timeout=1 and S_GAP; 4 edges later S_RUN.
//      -> o_timeout stays 1 across sw_rst_req and clears only on rst.
//   6. GAP_CYC=0 build
//      -> o_core_rst falls on the same edge mem_init_done is accepted in S_MEM.

Source files
------------

// File: rtl/rst_seq.sv
// Reset release sequencer: stretch, release memory reset, wait for init done, guard gap, release core.
// Optional mem-init wait timeout is built when RST_SEQ_TIMEOUT_EN is defined.
module rst_seq #(
  parameter int STRETCH_CYC = 16,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_init_done,
  input  logic       sw_rst_req,
  output logic       o_mem_rst,
  output logic       o_core_rst,
  output logic       o_rst_done,
  output logic       o_timeout,
  output logic [2:0] o_state
);

  localparam logic [2:0] S_HOLD    = 3'd0;
  localparam logic [2:0] S_STRETCH = 3'd1;
  localparam logic [2:0] S_MEM     = 3'd2;
  localparam logic [2:0] S_GAP     = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;

  localparam int MAX_AB  = (STRETCH_CYC > GAP_CYC) ? STRETCH_CYC : GAP_CYC;
  localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYC) ? MAX_AB : TIMEOUT_CYC;

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_TOP      = CNT_W'(MAX_CYC - 1);
  localparam logic [2:0]       S_AFTER_MEM  = (GAP_CYC == 0) ? S_RUN : S_GAP;

  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;

`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic timeout_q, timeout_nx;
`endif

  // Saturating increment so the counter can never wrap inside a state
  assign cnt_inc = (cnt == CNT_TOP) ? cnt : cnt + CNT_W'(1);

  // State register and registered outputs derived from next-state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_HOLD;
      cnt        <= '0;
      o_mem_rst  <= 1'b1;
      o_core_rst <= 1'b1;
      o_rst_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      o_mem_rst  <= (state_nx == S_HOLD) || (state_nx == S_STRETCH);
      o_core_rst <= (state_nx != S_RUN);
      o_rst_done <= (state_nx == S_RUN);
    end
  end

`ifdef RST_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) timeout_q <= 1'b0;
    else     timeout_q <= timeout_nx;
  end
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  // Next-state and counter
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
`ifdef RST_SEQ_TIMEOUT_EN
    timeout_nx = timeout_q;
`endif
    case (state)
      S_HOLD: begin
        state_nx = S_STRETCH;
        cnt_nx   = '0;
      end
      S_STRETCH: begin
        if (sw_rst_req) begin
          cnt_nx = '0;
        end else if (cnt == STRETCH_LAST) begin
          state_nx = S_MEM;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      S_MEM: begin
        if (sw_rst_req) begin
          state_nx = S_STRETCH;
          cnt_nx   = '0;
        end else if (mem_init_done) begin
          state_nx = S_AFTER_MEM;
          cnt_nx   = '0;
`ifdef RST_SEQ_TIMEOUT_EN
        end else if (cnt == TO_LAST) begin
          state_nx   = S_AFTER_MEM;
          cnt_nx     = '0;
          timeout_nx = 1'b1;
        end else begin
          cnt_nx = cnt_inc;
`endif
        end
      end
      S_GAP: begin
        if (sw_rst_req) begin
          state_nx = S_STRETCH;
          cnt_nx   = '0;
        end else if (cnt == GAP_LAST) begin
          state_nx = S_RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      S_RUN: begin
        if (sw_rst_req) begin
          state_nx = S_STRETCH;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = S_HOLD;
        cnt_nx   = '0;
      end
    endcase
  end

  assign o_state = state;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: main instance (GAP_CYC=4) plus a GAP_CYC=0 instance on shared inputs.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       rst, mem_init_done, sw_rst_req;
  logic       mem_rst, core_rst, rst_done, timeout;
  logic [2:0] state;
  logic       g0_mem_rst, g0_core_rst, g0_rst_done, g0_timeout;
  logic [2:0] g0_state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rst_seq #(.STRETCH_CYC(16), .GAP_CYC(4), .TIMEOUT_CYC(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .mem_init_done(mem_init_done), .sw_rst_req(sw_rst_req),
    .o_mem_rst(mem_rst), .o_core_rst(core_rst), .o_rst_done(rst_done),
    .o_timeout(timeout), .o_state(state)
  );

  rst_seq #(.STRETCH_CYC(16), .GAP_CYC(0), .TIMEOUT_CYC(32), .CNT_W(8)) dut_g0 (
    .clk(clk), .rst(rst), .mem_init_done(mem_init_done), .sw_rst_req(sw_rst_req),
    .o_mem_rst(g0_mem_rst), .o_core_rst(g0_core_rst), .o_rst_done(g0_rst_done),
    .o_timeout(g0_timeout), .o_state(g0_state)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic m, input logic c, input logic d,
                         input logic [2:0] s);
    chk({tag, ".mem_rst"},  {7'd0, mem_rst},  {7'd0, m});
    chk({tag, ".core_rst"}, {7'd0, core_rst}, {7'd0, c});
    chk({tag, ".rst_done"}, {7'd0, rst_done}, {7'd0, d});
    chk({tag, ".state"},    {5'd0, state},    {5'd0, s});
  endtask

  task automatic pulse_sw();
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_init_done = 1'b1; sw_rst_req = 1'b0;
    step(5);
    chk_all("reset", 1, 1, 0, 3'd0);
    chk("reset.timeout", {7'd0, timeout}, 8'd0);

    // Power-on sequence with done already high
    rst = 1'b0;
    step(1);  chk_all("t1.e0", 1, 1, 0, 3'd1);
    step(15); chk_all("t1.e15", 1, 1, 0, 3'd1);
    step(1);  chk_all("t1.e16", 0, 1, 0, 3'd2);
    chk("t1.g0_core_mem", {7'd0, g0_core_rst}, 8'd1);
    step(1);  chk_all("t1.e17", 0, 1, 0, 3'd3);
    chk("t1.g0_core", {7'd0, g0_core_rst}, 8'd0);
    chk("t1.g0_done", {7'd0, g0_rst_done}, 8'd1);
    chk("t1.g0_state", {5'd0, g0_state}, 8'd4);
    step(3);  chk_all("t1.e20", 0, 1, 0, 3'd3);
    step(1);  chk_all("t1.e21", 0, 0, 1, 3'd4);

    // Software reset replay with late done, done dropped during the gap
    mem_init_done = 1'b0;
    pulse_sw();  chk_all("t3.sw", 1, 1, 0, 3'd1);
    step(15); chk_all("t3.s15", 1, 1, 0, 3'd1);
    step(1);  chk_all("t3.s16", 0, 1, 0, 3'd2);
    step(10); chk_all("t2.wait10", 0, 1, 0, 3'd2);
    mem_init_done = 1'b1;
    step(1);  chk_all("t2.acc", 0, 1, 0, 3'd3);
    chk("t6.g0_core", {7'd0, g0_core_rst}, 8'd0);
    chk("t6.g0_state", {5'd0, g0_state}, 8'd4);
    mem_init_done = 1'b0;
    step(3);  chk_all("t2.gap3", 0, 1, 0, 3'd3);
    step(1);  chk_all("t2.run", 0, 0, 1, 3'd4);
    step(3);  chk_all("t2.run_hold", 0, 0, 1, 3'd4);

    // sw_rst_req in S_STRETCH restarts the count; in S_MEM it returns to S_STRETCH
    pulse_sw();
    step(8);
    pulse_sw();
    step(15); chk_all("ext.s15", 1, 1, 0, 3'd1);
    step(1);  chk_all("ext.s16", 0, 1, 0, 3'd2);
    step(2);
    pulse_sw(); chk_all("mem.sw", 1, 1, 0, 3'd1);

    // rst mid-stretch, and rst dominating sw_rst_req
    step(3);
    rst = 1'b1; sw_rst_req = 1'b1;
    step(1);  chk_all("t4.rst_str", 1, 1, 0, 3'd0);
    sw_rst_req = 1'b0;
    mem_init_done = 1'b1;
    rst = 1'b0;
    step(1);  chk_all("t4.r1", 1, 1, 0, 3'd1);
    step(16); chk_all("t4.r16", 0, 1, 0, 3'd2);
    step(1);  chk_all("t4.r17", 0, 1, 0, 3'd3);
    step(2);
    rst = 1'b1;
    step(1);  chk_all("t4.rst_gap", 1, 1, 0, 3'd0);
    rst = 1'b0;
    step(1);  chk_all("t4.c1", 1, 1, 0, 3'd1);
    step(16); chk_all("t4.c16", 0, 1, 0, 3'd2);
    step(1);  chk_all("t4.c17", 0, 1, 0, 3'd3);
    step(4);  chk_all("t4.c21", 0, 0, 1, 3'd4);

`ifdef RST_SEQ_TIMEOUT_EN
    // Timeout path with done held low
    mem_init_done = 1'b0;
    pulse_sw();
    step(16); chk_all("t5.mem", 0, 1, 0, 3'd2);
    step(31); chk_all("t5.e31", 0, 1, 0, 3'd2);
    chk("t5.to_pre", {7'd0, timeout}, 8'd0);
    step(1);  chk_all("t5.e32", 0, 1, 0, 3'd3);
    chk("t5.to_set", {7'd0, timeout}, 8'd1);
    step(4);  chk_all("t5.run", 0, 0, 1, 3'd4);
    pulse_sw(); chk("t5.to_sw", {7'd0, timeout}, 8'd1);
    rst = 1'b1;
    step(1);  chk("t5.to_rst", {7'd0, timeout}, 8'd0);
    rst = 1'b0;
    step(1);
`else
    // Without the timeout feature S_MEM waits indefinitely
    mem_init_done = 1'b0;
    pulse_sw();
    step(16); chk_all("nto.mem", 0, 1, 0, 3'd2);
    step(60); chk_all("nto.wait", 0, 1, 0, 3'd2);
    chk("nto.timeout", {7'd0, timeout}, 8'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
